decode_queue_stage: RTL and testbench

//  Parametrised decode stage: decodes fetched RV32 insts (decoder + immed_gen), reads RF, and buffers

---
 rtl/decode_queue_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_decode_queue_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue_stage.sv
// RV32 decode stage: decodes and reads operands for fetched instructions and buffers the
// decoded entries in an in-order valid/ready queue toward execute, with writeback snooping.
package decode_queue_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] next_pc;
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] next_pc;
      logic [31:0] imm;
      logic [3:0]  alu_op;
      logic [2:0]  funct3;
      logic        alu_src_imm;
      logic        alu_src_pc;
      logic        branch;
      logic        jump;
      logic        jalr;
      logic        mem_read;
      logic        mem_write;
      logic        rf_wr_en;
      logic [1:0]  wb_sel;      // 0 alu, 1 mem, 2 pc+4, 3 csr
      logic        csr_wr;
      logic        csr_mret;
      logic [11:0] csr_addr;
      logic [1:0]  csr_mode;
      logic [4:0]  csr_immed;
      logic        csr_immed_sel;
   } decode_state_t;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rs1_used;
      logic        rs2_used;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
   } reg_meta_t;
endpackage

module decode_queue_stage
   import decode_queue_pkg::*;
#(
   parameter int unsigned DEPTH         = 2,
   parameter bit          CHECK_ILLEGAL = 1'b1,
   parameter bit          SNOOP_WB      = 1'b1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         fetch_valid_i,
   output logic                         fetch_ready_o,
   input  fetch_state_t                 fetch_state_i,
   input  logic [31:0]                  inst_i,
   input  logic                         squash_i,
   output logic [4:0]                   rf_port1_reg_o,
   output logic [4:0]                   rf_port2_reg_o,
   input  logic [31:0]                  rf_rs1_i,
   input  logic [31:0]                  rf_rs2_i,
   input  logic                         wb_valid_i,
   input  logic [4:0]                   wb_rd_i,
   input  logic [31:0]                  wb_data_i,
   output logic                         ex_valid_o,
   input  logic                         ex_ready_i,
   output decode_state_t                decode_state_o,
   output reg_meta_t                    reg_meta_o,
   output logic                         illegal_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   localparam logic [4:0] OpLoad    = 5'b00000;
   localparam logic [4:0] OpMiscMem = 5'b00011;
   localparam logic [4:0] OpOpImm   = 5'b00100;
   localparam logic [4:0] OpAuipc   = 5'b00101;
   localparam logic [4:0] OpStore   = 5'b01000;
   localparam logic [4:0] OpOp      = 5'b01100;
   localparam logic [4:0] OpLui     = 5'b01101;
   localparam logic [4:0] OpBranch  = 5'b11000;
   localparam logic [4:0] OpJalr    = 5'b11001;
   localparam logic [4:0] OpJal     = 5'b11011;
   localparam logic [4:0] OpSystem  = 5'b11100;

   decode_state_t dec_ds;
   reg_meta_t     dec_meta;
   logic          dec_ill;
   logic          known;
   logic [2:0]    funct3;
   logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
   logic          snoop_en, enq, deq;

   logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   decode_state_t ds_mem   [DEPTH];
   reg_meta_t     meta_mem [DEPTH];
   logic          ill_mem  [DEPTH];

   assign funct3 = inst_i[14:12];
   assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u  = {inst_i[31:12], 12'h000};
   assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   assign rf_port1_reg_o = inst_i[19:15];
   assign rf_port2_reg_o = inst_i[24:20];
   assign snoop_en       = SNOOP_WB && wb_valid_i && (wb_rd_i != 5'd0);

   always_comb begin
      dec_ds   = '0;
      dec_meta = '0;
      known    = 1'b1;
      dec_ds.pc            = fetch_state_i.pc;
      dec_ds.next_pc       = fetch_state_i.next_pc;
      dec_ds.funct3        = funct3;
      dec_ds.csr_addr      = inst_i[31:20];
      dec_ds.csr_mode      = inst_i[13:12];
      dec_ds.csr_immed     = inst_i[19:15];
      dec_ds.csr_immed_sel = inst_i[14];
      dec_meta.rs1         = inst_i[19:15];
      dec_meta.rs2         = inst_i[24:20];
      dec_meta.rd          = inst_i[11:7];
      case (inst_i[6:2])
         OpLui:   begin dec_ds.rf_wr_en = 1'b1; dec_ds.alu_src_imm = 1'b1; dec_ds.imm = imm_u; end
         OpAuipc: begin
            dec_ds.rf_wr_en   = 1'b1; dec_ds.alu_src_imm = 1'b1;
            dec_ds.alu_src_pc = 1'b1; dec_ds.imm         = imm_u;
         end
         OpJal:   begin
            dec_ds.rf_wr_en = 1'b1; dec_ds.jump = 1'b1; dec_ds.wb_sel = 2'd2; dec_ds.imm = imm_j;
         end
         OpJalr:  begin
            dec_ds.rf_wr_en = 1'b1; dec_ds.jump   = 1'b1; dec_ds.jalr = 1'b1;
            dec_ds.wb_sel   = 2'd2; dec_ds.imm    = imm_i; dec_meta.rs1_used = 1'b1;
         end
         OpBranch: begin
            dec_ds.branch = 1'b1; dec_ds.imm = imm_b;
            dec_meta.rs1_used = 1'b1; dec_meta.rs2_used = 1'b1;
         end
         OpLoad:  begin
            dec_ds.rf_wr_en = 1'b1; dec_ds.mem_read = 1'b1; dec_ds.alu_src_imm = 1'b1;
            dec_ds.wb_sel   = 2'd1; dec_ds.imm      = imm_i; dec_meta.rs1_used  = 1'b1;
         end
         OpStore: begin
            dec_ds.mem_write = 1'b1; dec_ds.alu_src_imm = 1'b1; dec_ds.imm = imm_s;
            dec_meta.rs1_used = 1'b1; dec_meta.rs2_used = 1'b1;
         end
         OpOpImm: begin
            dec_ds.rf_wr_en = 1'b1; dec_ds.alu_src_imm = 1'b1; dec_ds.imm = imm_i;
            dec_ds.alu_op   = {(funct3 == 3'b101) & inst_i[30], funct3};
            dec_meta.rs1_used = 1'b1;
         end
         OpOp:    begin
            dec_ds.rf_wr_en   = 1'b1; dec_ds.alu_op = {inst_i[30], funct3};
            dec_meta.rs1_used = 1'b1; dec_meta.rs2_used = 1'b1;
         end
         OpMiscMem: ;
         OpSystem: begin
            dec_ds.imm = imm_i;
            if (funct3 != 3'b000) begin
               dec_ds.rf_wr_en   = 1'b1; dec_ds.csr_wr = 1'b1; dec_ds.wb_sel = 2'd3;
               dec_meta.rs1_used = ~inst_i[14];
            end else begin
               dec_ds.csr_mret = (inst_i[31:20] == 12'h302);
            end
         end
         default: known = 1'b0;
      endcase
      dec_ill = CHECK_ILLEGAL && ((inst_i[1:0] != 2'b11) || !known);
      // Writes to x0 are dropped here so execute never has to special-case them.
      dec_ds.rf_wr_en  = dec_ds.rf_wr_en & (dec_meta.rd != 5'd0) & ~dec_ill;
      dec_ds.mem_read  = dec_ds.mem_read & ~dec_ill;
      dec_ds.mem_write = dec_ds.mem_write & ~dec_ill;
      dec_ds.csr_wr    = dec_ds.csr_wr & ~dec_ill;
      dec_ds.csr_mret  = dec_ds.csr_mret & ~dec_ill;
      dec_meta.rs1_data = (snoop_en && dec_meta.rs1_used && dec_meta.rs1 == wb_rd_i) ?
                          wb_data_i : rf_rs1_i;
      dec_meta.rs2_data = (snoop_en && dec_meta.rs2_used && dec_meta.rs2 == wb_rd_i) ?
                          wb_data_i : rf_rs2_i;
   end

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign fetch_ready_o = (cnt_q != CntW'(DEPTH));
   assign ex_valid_o    = (cnt_q != '0);
   assign count_o       = cnt_q;
   assign enq           = fetch_valid_i & fetch_ready_o & ~squash_i;
   assign deq           = ex_valid_o & ex_ready_i;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (squash_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (enq) wr_d = ptr_inc(wr_q);
         if (deq) rd_d = ptr_inc(rd_q);
         if (enq && !deq)      cnt_d = cnt_q + CntW'(1);
         else if (deq && !enq) cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Snooping free slots is harmless: they are fully rewritten on enqueue.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (enq && wr_q == PtrW'(i)) begin
            ds_mem[i]   <= dec_ds;
            meta_mem[i] <= dec_meta;
            ill_mem[i]  <= dec_ill;
         end else if (snoop_en) begin
            if (meta_mem[i].rs1_used && meta_mem[i].rs1 == wb_rd_i) meta_mem[i].rs1_data <= wb_data_i;
            if (meta_mem[i].rs2_used && meta_mem[i].rs2 == wb_rd_i) meta_mem[i].rs2_data <= wb_data_i;
         end
      end
   end

   assign decode_state_o = ex_valid_o ? ds_mem[rd_q]   : '0;
   assign reg_meta_o     = ex_valid_o ? meta_mem[rd_q] : '0;
   assign illegal_o      = ex_valid_o & ill_mem[rd_q];

endmodule

// File: tb/tb_decode_queue_stage.sv
// Randomized and directed bench for decode_queue_stage, checked against a queue-based model
// that derives each entry's expected fields from the RV32 encoding rules.
module tb_decode_queue_stage;
   import decode_queue_pkg::*;

   localparam int unsigned Depth = 2;

   localparam logic [4:0] LUI = 5'b01101, AUIPC = 5'b00101, JAL = 5'b11011, JALR = 5'b11001;
   localparam logic [4:0] BRANCH = 5'b11000, LOAD = 5'b00000, STORE = 5'b01000;
   localparam logic [4:0] OPIMM = 5'b00100, OP = 5'b01100, MISCMEM = 5'b00011, SYSTEM = 5'b11100;

   logic clk_i = 1'b0;
   logic rst_ni;
   logic fetch_valid_i, fetch_ready_o, squash_i, wb_valid_i, ex_valid_o, ex_ready_i, illegal_o;
   fetch_state_t  fetch_state_i;
   logic [31:0]   inst_i, rf_rs1_i, rf_rs2_i, wb_data_i;
   logic [4:0]    rf_port1_reg_o, rf_port2_reg_o, wb_rd_i;
   decode_state_t decode_state_o;
   reg_meta_t     reg_meta_o;
   logic [$clog2(Depth+1)-1:0] count_o;

   always #5 clk_i = ~clk_i;

   decode_queue_stage #(.DEPTH(Depth), .CHECK_ILLEGAL(1'b1), .SNOOP_WB(1'b1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
      .fetch_state_i(fetch_state_i), .inst_i(inst_i), .squash_i(squash_i),
      .rf_port1_reg_o(rf_port1_reg_o), .rf_port2_reg_o(rf_port2_reg_o),
      .rf_rs1_i(rf_rs1_i), .rf_rs2_i(rf_rs2_i),
      .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
      .decode_state_o(decode_state_o), .reg_meta_o(reg_meta_o),
      .illegal_o(illegal_o), .count_o(count_o)
   );

   typedef struct {
      logic [31:0] inst, pc, next_pc, rs1_data, rs2_data;
   } exp_t;

   exp_t        model_q[$];
   logic [31:0] dut_out[$];
   int unsigned n_vec = 0, n_err = 0;
   bit          last_enq;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_illegal(input logic [31:0] w);
      return (w[1:0] != 2'b11) ||
             !(w[6:2] inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, MISCMEM, SYSTEM});
   endfunction

   function automatic bit exp_rf_wr(input logic [31:0] w);
      bit writes = (w[6:2] inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP}) ||
                   (w[6:2] == SYSTEM && w[14:12] != 3'b000);
      return writes && !exp_illegal(w) && w[11:7] != 5'd0;
   endfunction

   function automatic bit rs1_used(input logic [31:0] w);
      return (w[6:2] inside {JALR, BRANCH, LOAD, STORE, OPIMM, OP}) ||
             (w[6:2] == SYSTEM && w[14:12] != 3'b000 && !w[14]);
   endfunction

   function automatic bit rs2_used(input logic [31:0] w);
      return w[6:2] inside {BRANCH, STORE, OP};
   endfunction

   function automatic logic [31:0] exp_imm(input logic [31:0] w);
      logic signed [11:0] i12;
      logic signed [12:0] b13;
      logic signed [20:0] j21;
      case (w[6:2])
         JALR, LOAD, OPIMM, SYSTEM: begin i12 = w[31:20]; return 32'(i12); end
         STORE:      begin i12 = {w[31:25], w[11:7]}; return 32'(i12); end
         BRANCH:     begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; return 32'(b13); end
         LUI, AUIPC: return {w[31:12], 12'h000};
         JAL:        begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; return 32'(j21); end
         default:    return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 10))
         0: w[6:2] = LUI;    1: w[6:2] = AUIPC;  2: w[6:2] = JAL;     3: w[6:2] = JALR;
         4: w[6:2] = BRANCH; 5: w[6:2] = LOAD;   6: w[6:2] = STORE;   7: w[6:2] = OPIMM;
         8: w[6:2] = OP;     9: w[6:2] = MISCMEM; default: w[6:2] = SYSTEM;
      endcase
      w[1:0]   = 2'b11;
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) w = $urandom;
      return w;
   endfunction

   task automatic idle();
      fetch_valid_i = 1'b0; squash_i = 1'b0; ex_ready_i = 1'b0; wb_valid_i = 1'b0;
      wb_rd_i = '0; wb_data_i = '0; inst_i = '0; rf_rs1_i = '0; rf_rs2_i = '0;
      fetch_state_i = '0;
   endtask

   task automatic drive(input logic [31:0] w, input logic [31:0] pc);
      fetch_valid_i = 1'b1;
      inst_i        = w;
      fetch_state_i = '{pc: pc, next_pc: pc + 32'd4};
   endtask

   // Called just after a negedge with inputs set; checks, advances the model, waits one cycle.
   task automatic step();
      bit   enq, deq, hit;
      int   sz;
      exp_t e;
      #1;
      sz = model_q.size();
      check("count", 32'(count_o), 32'(sz));
      check("ex_valid", 32'(ex_valid_o), 32'(sz != 0));
      check("fetch_ready", 32'(fetch_ready_o), 32'(sz != Depth));
      check("rf_port1", 32'(rf_port1_reg_o), 32'(inst_i[19:15]));
      check("rf_port2", 32'(rf_port2_reg_o), 32'(inst_i[24:20]));
      if (sz != 0) begin
         e = model_q[0];
         check("head_pc", decode_state_o.pc, e.pc);
         check("head_next_pc", decode_state_o.next_pc, e.next_pc);
         check("head_imm", decode_state_o.imm, exp_imm(e.inst));
         check("head_rf_wr_en", 32'(decode_state_o.rf_wr_en), 32'(exp_rf_wr(e.inst)));
         check("head_mem_read", 32'(decode_state_o.mem_read),
               32'(e.inst[6:2] == LOAD && !exp_illegal(e.inst)));
         check("head_mem_write", 32'(decode_state_o.mem_write),
               32'(e.inst[6:2] == STORE && !exp_illegal(e.inst)));
         check("head_csr_addr", 32'(decode_state_o.csr_addr), 32'(e.inst[31:20]));
         check("head_illegal", 32'(illegal_o), 32'(exp_illegal(e.inst)));
         check("head_regs", {17'h0, reg_meta_o.rs1, reg_meta_o.rs2, reg_meta_o.rd},
               {17'h0, e.inst[19:15], e.inst[24:20], e.inst[11:7]});
         check("head_used", {30'h0, reg_meta_o.rs1_used, reg_meta_o.rs2_used},
               {30'h0, rs1_used(e.inst), rs2_used(e.inst)});
         check("head_rs1_data", reg_meta_o.rs1_data, e.rs1_data);
         check("head_rs2_data", reg_meta_o.rs2_data, e.rs2_data);
      end else begin
         check("gated_outputs", 32'(|{decode_state_o, reg_meta_o, illegal_o}), 32'h0);
      end
      if (ex_valid_o && ex_ready_i) dut_out.push_back(decode_state_o.pc);

      enq = fetch_valid_i && sz != Depth && !squash_i;
      deq = sz != 0 && ex_ready_i;
      hit = wb_valid_i && wb_rd_i != 5'd0;
      foreach (model_q[i]) begin
         if (hit && rs1_used(model_q[i].inst) && model_q[i].inst[19:15] == wb_rd_i)
            model_q[i].rs1_data = wb_data_i;
         if (hit && rs2_used(model_q[i].inst) && model_q[i].inst[24:20] == wb_rd_i)
            model_q[i].rs2_data = wb_data_i;
      end
      e.inst     = inst_i;
      e.pc       = fetch_state_i.pc;
      e.next_pc  = fetch_state_i.next_pc;
      e.rs1_data = (hit && rs1_used(inst_i) && inst_i[19:15] == wb_rd_i) ? wb_data_i : rf_rs1_i;
      e.rs2_data = (hit && rs2_used(inst_i) && inst_i[24:20] == wb_rd_i) ? wb_data_i : rf_rs2_i;
      if (squash_i) begin
         model_q.delete();
      end else begin
         if (deq) void'(model_q.pop_front());
         if (enq) model_q.push_back(e);
      end
      last_enq = enq;
      @(negedge clk_i);
   endtask

   initial begin
      int k, cyc;
      idle();
      rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      step();

      // Fill to full, then drain in order.
      idle();
      drive(32'h00100093, 32'h100); step();
      drive(32'h00100093, 32'h104); step();
      #1;
      check("t1_full_count", 32'(count_o), 32'd2);
      check("t1_full_ready", 32'(fetch_ready_o), 32'd0);
      idle(); ex_ready_i = 1'b1;
      check("t1_head0", decode_state_o.pc, 32'h100);
      step();
      check("t1_head1", decode_state_o.pc, 32'h104);
      step();
      check("t1_empty", {31'h0, ex_valid_o}, 32'h0);
      step();

      // Pointer wrap with execute toggling ready every cycle.
      idle(); dut_out.delete(); k = 0; cyc = 0;
      while (k < 8 && cyc < 100) begin
         drive(32'h00208033, 32'(k * 4));
         ex_ready_i = cyc[0];
         step();
         if (last_enq) k++;
         cyc++;
      end
      idle(); ex_ready_i = 1'b1;
      repeat (4) step();
      check("t2_out_count", 32'(dut_out.size()), 32'd8);
      for (int i = 0; i < dut_out.size() && i < 8; i++) check("t2_order", dut_out[i], 32'(i * 4));

      // Writeback snoop after enqueue, during enqueue, and to x0.
      idle();
      drive(32'h002081B3, 32'h200); rf_rs1_i = 32'd5; rf_rs2_i = 32'd7; step();
      idle(); wb_valid_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'h22; step();
      idle(); ex_ready_i = 1'b1;
      check("t3_snoop_rs1", reg_meta_o.rs1_data, 32'h22);
      check("t3_snoop_rs2", reg_meta_o.rs2_data, 32'd7);
      step();
      idle();
      drive(32'h002081B3, 32'h204); rf_rs1_i = 32'd5; rf_rs2_i = 32'd7;
      wb_valid_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'h22; step();
      idle(); ex_ready_i = 1'b1;
      check("t3_snoop_enq", reg_meta_o.rs1_data, 32'h22);
      step();
      idle();
      drive(32'h002001B3, 32'h208); rf_rs1_i = 32'd5; rf_rs2_i = 32'd7; step();
      idle(); wb_valid_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'h99; step();
      idle(); ex_ready_i = 1'b1;
      check("t3_snoop_x0", reg_meta_o.rs1_data, 32'd5);
      step();

      // Squash with a full queue and a new fetch pending.
      idle();
      drive(32'h00100093, 32'h300); step();
      drive(32'h00100093, 32'h304); step();
      drive(32'h00100093, 32'h308); squash_i = 1'b1; ex_ready_i = 1'b1; step();
      #1;
      check("t4_count", 32'(count_o), 32'd0);
      check("t4_valid", {31'h0, ex_valid_o}, 32'h0);
      idle(); ex_ready_i = 1'b1; dut_out.delete();
      repeat (3) step();
      check("t4_no_emit", 32'(dut_out.size()), 32'd0);

      // x0 destination and an illegal all-zero word.
      idle();
      drive(32'h00100013, 32'h400); step();
      idle();
      check("t5_addi_x0_wr", {31'h0, decode_state_o.rf_wr_en}, 32'h0);
      ex_ready_i = 1'b1; step();
      idle();
      drive(32'h00000000, 32'h404); step();
      idle();
      check("t5_illegal", {31'h0, illegal_o}, 32'h1);
      check("t5_ill_mem_write", {31'h0, decode_state_o.mem_write}, 32'h0);
      check("t5_ill_rf_wr", {31'h0, decode_state_o.rf_wr_en}, 32'h0);
      ex_ready_i = 1'b1; step();

      // Asynchronous reset between clock edges.
      idle();
      drive(32'h00100093, 32'h500); step();
      idle();
      #2; rst_ni = 1'b0; #1;
      check("t6_rst_valid", {31'h0, ex_valid_o}, 32'h0);
      check("t6_rst_count", 32'(count_o), 32'd0);
      model_q.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         fetch_valid_i = ($urandom_range(0, 3) != 0);
         inst_i        = rand_inst();
         fetch_state_i.pc      = $urandom & 32'hFFFF_FFFC;
         fetch_state_i.next_pc = fetch_state_i.pc + 32'd4;
         rf_rs1_i   = $urandom;
         rf_rs2_i   = $urandom;
         squash_i   = ($urandom_range(0, 19) == 0);
         ex_ready_i = $urandom_range(0, 1) == 1;
         wb_valid_i = $urandom_range(0, 1) == 1;
         wb_rd_i    = 5'($urandom_range(0, 3));
         wb_data_i  = $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
